// File: rtl/arbiter_age_n_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_age_n_pkg
// Brief    : Shared constants and helpers for the oldest-first arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package arbiter_age_n_pkg;

    localparam int c_MAX_N   = 16;
    localparam bit c_LOCK    = 1'b1;
    localparam bit c_NOLOCK  = 1'b0;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [c_MAX_N-1:0] onehot(input int idx);
        return c_MAX_N'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arbiter_age_n_if.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_age_n_if
// Brief    : Request/grant bundle between input ports and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface arbiter_age_n_if #(
    parameter int N = 4
);
    localparam int IDXW = arbiter_age_n_pkg::idx_width(N);

    logic [N-1:0]    request;
    logic            buffer_full_i;
    logic            tail_i;
    logic [N-1:0]    grant;
    logic            grant_v_o;
    logic [IDXW-1:0] grant_idx_o;
    logic [IDXW:0]   occupancy_o;
    logic            err_o;

    modport master (
        output request, buffer_full_i, tail_i,
        input  grant, grant_v_o, grant_idx_o, occupancy_o, err_o
    );

    modport slave (
        input  request, buffer_full_i, tail_i,
        output grant, grant_v_o, grant_idx_o, occupancy_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/rot_prio_order.sv
`default_nettype none
// ============================================================================
// Module   : rot_prio_order
// Brief    : Lists set bits of a vector in rotating order from a start index.
// Revision : 1.0 - initial release
// ============================================================================
module rot_prio_order
    import arbiter_age_n_pkg::*;
#(
    parameter  int N    = 4,
    localparam int IDXW = idx_width(N)
) (
    input  logic [N-1:0]           vec_i,
    input  logic [IDXW-1:0]        start_i,
    output logic [N-1:0][IDXW-1:0] order_o,
    output logic [IDXW:0]          count_o
);

    always_comb begin
        int              j;
        int              n_found;
        logic [IDXW-1:0] idx;
        order_o = '0;
        n_found = 0;
        j       = 0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(start_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            idx = IDXW'(j);
            if (vec_i[idx]) begin
                for (int p = 0; p < N; p++) begin
                    if (p == n_found) begin
                        order_o[p] = idx;
                    end
                end
                n_found++;
            end
        end
        count_o = (IDXW+1)'(n_found);
    end

endmodule
`default_nettype wire

// File: rtl/arbiter_age_n.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_age_n
// Brief    : N-requester oldest-first arbiter with packet lock and back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module arbiter_age_n
    import arbiter_age_n_pkg::*;
#(
    parameter  int N       = 4,
    parameter  bit LOCK_EN = c_LOCK,
    localparam int IDXW    = idx_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    arbiter_age_n_if.slave bus
);

    typedef logic [IDXW-1:0] idx_t;

    idx_t [N-1:0]  q_idx_q, q_idx_d;
    logic [IDXW:0] count_q, count_d;
    idx_t          rr_ptr_q, rr_ptr_d;
    logic          lock_q, lock_d;

    idx_t          head;
    logic          grant_v;
    logic          deq;
    logic          err;
    logic [N-1:0]  queued_mask;
    logic [N-1:0]  deq_mask;
    logic [N-1:0]  arrivals;
    logic [N-1:0]  keep;
    idx_t [N-1:0]  arr_order;
    logic [IDXW:0] arr_count;

    rot_prio_order #(
        .N (N)
    ) u_rot_prio_order (
        .vec_i   (arrivals),
        .start_i (rr_ptr_q),
        .order_o (arr_order),
        .count_o (arr_count)
    );

    // Decode of the current cycle from registered queue and live inputs.
    always_comb begin
        head        = q_idx_q[0];
        grant_v     = (count_q != '0) && !bus.buffer_full_i && bus.request[head];
        deq         = grant_v && (!LOCK_EN || bus.tail_i);
        err         = lock_q && (count_q != '0) && !bus.request[head];
        deq_mask    = deq ? N'(onehot(int'(head))) : '0;
        queued_mask = '0;
        keep        = '0;
        for (int e = 0; e < N; e++) begin
            if (e < int'(count_q)) begin
                queued_mask = queued_mask | N'(onehot(int'(q_idx_q[e])));
                keep[e]     = bus.request[q_idx_q[e]] && !((e == 0) && deq);
            end
        end
        arrivals = bus.request & ~queued_mask & ~deq_mask;
    end

    // Survivors keep their relative order; arrivals land behind them.
    always_comb begin
        int rank;
        int surv;
        q_idx_d = '0;
        rank    = 0;
        surv    = $countones(keep);
        for (int p = 0; p < N; p++) begin
            rank = 0;
            for (int e = 0; e < N; e++) begin
                if (keep[e] && (rank == p)) begin
                    q_idx_d[p] = q_idx_q[e];
                end
                if (keep[e]) begin
                    rank++;
                end
            end
            for (int a = 0; a < N; a++) begin
                if ((a < int'(arr_count)) && ((surv + a) == p)) begin
                    q_idx_d[p] = arr_order[a];
                end
            end
        end
        count_d = (IDXW+1)'(surv) + arr_count;

        rr_ptr_d = rr_ptr_q;
        lock_d   = lock_q;
        if (deq) begin
            rr_ptr_d = (head == idx_t'(N-1)) ? '0 : head + idx_t'(1);
            lock_d   = 1'b0;
        end else if (err) begin
            lock_d   = 1'b0;
        end else if (LOCK_EN && grant_v) begin
            lock_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_idx_q  <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
            lock_q   <= 1'b0;
        end else begin
            q_idx_q  <= q_idx_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            lock_q   <= lock_d;
        end
    end

    assign bus.grant       = grant_v ? N'(onehot(int'(head))) : '0;
    assign bus.grant_v_o   = grant_v;
    assign bus.grant_idx_o = grant_v ? head : '0;
    assign bus.occupancy_o = count_q;
    assign bus.err_o       = err;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_age_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbiter_age_n
// Brief    : Self-checking bench: non-locking and locking arbiter instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbiter_age_n;
    import arbiter_age_n_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    arbiter_age_n_if #(.N(N)) bus0 ();
    arbiter_age_n_if #(.N(N)) bus1 ();

    arbiter_age_n #(.N(N), .LOCK_EN(c_NOLOCK)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    arbiter_age_n #(.N(N), .LOCK_EN(c_LOCK))   u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        bit         do_rst;
        bit [1:0]   sel;     // bit0: non-locking instance, bit1: locking instance
        logic [3:0] req;
        bit         full;
        bit         tail;
        logic [3:0] g;
        int         occ;
        bit         err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(bit [1:0] sel, logic [3:0] req, bit full, bit tail,
                                logic [3:0] g, int occ, bit err);
        vec_t v;
        v.do_rst = 1'b0; v.sel = sel; v.req = req; v.full = full; v.tail = tail;
        v.g = g; v.occ = occ; v.err = err;
        return v;
    endfunction

    function automatic vec_t mk_rst();
        vec_t v;
        v = mk(2'b11, 4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1'b0);
        v.do_rst = 1'b1;
        return v;
    endfunction

    function automatic int exp_idx(logic [3:0] g);
        for (int i = 0; i < 4; i++) begin
            if (g[i]) return i;
        end
        return 0;
    endfunction

    task automatic drive(logic [3:0] req, bit full, bit tail);
        bus0.request = req; bus0.buffer_full_i = full; bus0.tail_i = tail;
        bus1.request = req; bus1.buffer_full_i = full; bus1.tail_i = tail;
    endtask

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(int d, vec_t e, int ri);
        logic [3:0] g;
        logic       v;
        logic [1:0] idx;
        logic [2:0] occ;
        logic       er;
        if (d == 0) begin
            g = bus0.grant; v = bus0.grant_v_o; idx = bus0.grant_idx_o;
            occ = bus0.occupancy_o; er = bus0.err_o;
        end else begin
            g = bus1.grant; v = bus1.grant_v_o; idx = bus1.grant_idx_o;
            occ = bus1.occupancy_o; er = bus1.err_o;
        end
        chk($sformatf("row%0d dut%0d grant", ri, d),     int'(g),   int'(e.g));
        chk($sformatf("row%0d dut%0d grant_v", ri, d),   int'(v),   int'(|e.g));
        chk($sformatf("row%0d dut%0d grant_idx", ri, d), int'(idx), exp_idx(e.g));
        chk($sformatf("row%0d dut%0d occupancy", ri, d), int'(occ), e.occ);
        chk($sformatf("row%0d dut%0d err", ri, d),       int'(er),  int'(e.err));
    endtask

    // One cycle per vector: drive after the rising edge, compare at the falling edge.
    task automatic apply(vec_t v, int ri);
        vec_t e;
        @(posedge clk);
        #1;
        if (v.do_rst) begin
            rst = 1'b0;
            drive(4'b0000, 1'b0, 1'b0);
        end else begin
            drive(v.req, v.full, v.tail);
        end
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        if (e.sel[0]) check_dut(0, e, ri);
        if (e.sel[1]) check_dut(1, e, ri);
        if (v.do_rst) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        drive(4'b0000, 1'b0, 1'b0);

        // Re-enqueue behind a waiting requester.
        tbl.push_back(mk_rst());
        tbl.push_back(mk(3, 4'b0001, 0, 1, 4'b0000, 0, 0));
        tbl.push_back(mk(3, 4'b1001, 0, 1, 4'b0001, 1, 0));
        tbl.push_back(mk(3, 4'b1001, 0, 1, 4'b1000, 1, 0));
        tbl.push_back(mk(3, 4'b1001, 0, 1, 4'b0001, 1, 0));
        tbl.push_back(mk(3, 4'b0000, 0, 1, 4'b0000, 1, 0));
        tbl.push_back(mk(3, 4'b0000, 0, 1, 4'b0000, 0, 0));
        // All requesting, then simultaneous arrivals rotate from rr_ptr=1.
        tbl.push_back(mk_rst());
        tbl.push_back(mk(3, 4'b1111, 0, 1, 4'b0000, 0, 0));
        tbl.push_back(mk(3, 4'b1111, 0, 1, 4'b0001, 4, 0));
        tbl.push_back(mk(3, 4'b1111, 0, 1, 4'b0010, 3, 0));
        tbl.push_back(mk(3, 4'b1111, 0, 1, 4'b0100, 3, 0));
        tbl.push_back(mk(3, 4'b1111, 0, 1, 4'b1000, 3, 0));
        tbl.push_back(mk(3, 4'b1111, 0, 1, 4'b0001, 3, 0));
        tbl.push_back(mk(3, 4'b0000, 0, 1, 4'b0000, 3, 0));
        tbl.push_back(mk(3, 4'b1111, 0, 1, 4'b0000, 0, 0));
        tbl.push_back(mk(3, 4'b1111, 0, 1, 4'b0010, 4, 0));
        tbl.push_back(mk(3, 4'b0000, 0, 1, 4'b0000, 3, 0));
        tbl.push_back(mk(3, 4'b0000, 0, 1, 4'b0000, 0, 0));
        // Back-pressure: no grant, enqueue continues.
        tbl.push_back(mk_rst());
        tbl.push_back(mk(3, 4'b0010, 0, 1, 4'b0000, 0, 0));
        tbl.push_back(mk(3, 4'b0010, 1, 1, 4'b0000, 1, 0));
        tbl.push_back(mk(3, 4'b0110, 1, 1, 4'b0000, 1, 0));
        tbl.push_back(mk(3, 4'b0110, 1, 1, 4'b0000, 2, 0));
        tbl.push_back(mk(3, 4'b0110, 0, 1, 4'b0010, 2, 0));
        tbl.push_back(mk(3, 4'b0100, 0, 1, 4'b0100, 1, 0));
        tbl.push_back(mk(3, 4'b0000, 0, 1, 4'b0000, 0, 0));
        // Withdrawal of an unlocked head.
        tbl.push_back(mk_rst());
        tbl.push_back(mk(3, 4'b0100, 1, 1, 4'b0000, 0, 0));
        tbl.push_back(mk(3, 4'b0101, 1, 1, 4'b0000, 1, 0));
        tbl.push_back(mk(3, 4'b0001, 0, 1, 4'b0000, 2, 0));
        tbl.push_back(mk(3, 4'b0001, 0, 1, 4'b0001, 1, 0));
        tbl.push_back(mk(3, 4'b0000, 0, 1, 4'b0000, 0, 0));
        // Withdrawal of a locked head raises err.
        tbl.push_back(mk_rst());
        tbl.push_back(mk(2, 4'b0100, 1, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(2, 4'b0101, 1, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(2, 4'b0101, 0, 0, 4'b0100, 2, 0));
        tbl.push_back(mk(2, 4'b0001, 0, 0, 4'b0000, 2, 1));
        tbl.push_back(mk(2, 4'b0001, 0, 1, 4'b0001, 1, 0));
        tbl.push_back(mk(2, 4'b0000, 0, 1, 4'b0000, 0, 0));
        // Packet lock held until tail.
        tbl.push_back(mk_rst());
        tbl.push_back(mk(2, 4'b0110, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(2, 4'b0110, 0, 0, 4'b0010, 2, 0));
        tbl.push_back(mk(2, 4'b0110, 0, 0, 4'b0010, 2, 0));
        tbl.push_back(mk(2, 4'b0110, 0, 1, 4'b0010, 2, 0));
        tbl.push_back(mk(2, 4'b0110, 0, 1, 4'b0100, 1, 0));
        tbl.push_back(mk(2, 4'b0000, 0, 1, 4'b0000, 1, 0));
        tbl.push_back(mk(2, 4'b0000, 0, 1, 4'b0000, 0, 0));
        // Lock survives a back-pressure cycle.
        tbl.push_back(mk_rst());
        tbl.push_back(mk(2, 4'b0110, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(2, 4'b0110, 0, 0, 4'b0010, 2, 0));
        tbl.push_back(mk(2, 4'b0110, 1, 0, 4'b0000, 2, 0));
        tbl.push_back(mk(2, 4'b0110, 0, 0, 4'b0010, 2, 0));
        tbl.push_back(mk(2, 4'b0110, 0, 1, 4'b0010, 2, 0));
        tbl.push_back(mk(2, 4'b0110, 0, 1, 4'b0100, 1, 0));
        tbl.push_back(mk(2, 4'b0000, 0, 1, 4'b0000, 1, 0));
        tbl.push_back(mk(2, 4'b0000, 0, 1, 4'b0000, 0, 0));
        // Without locking, tail_i=0 still gives single-cycle grants.
        tbl.push_back(mk_rst());
        tbl.push_back(mk(1, 4'b0110, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(1, 4'b0110, 0, 0, 4'b0010, 2, 0));
        tbl.push_back(mk(1, 4'b0110, 0, 0, 4'b0100, 1, 0));
        tbl.push_back(mk(1, 4'b0110, 0, 0, 4'b0010, 1, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 1, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Asynchronous reset in the middle of a locked packet.
        apply(mk_rst(), 200);
        apply(mk(2, 4'b0111, 0, 0, 4'b0000, 0, 0), 201);
        apply(mk(2, 4'b0111, 0, 0, 4'b0001, 3, 0), 202);
        @(posedge clk);
        #1;
        drive(4'b0111, 1'b0, 1'b0);
        #2;
        chk("midrst pre grant", int'(bus1.grant), 1);
        chk("midrst pre occupancy", int'(bus1.occupancy_o), 3);
        rst = 1'b0;
        #1;
        chk("midrst grant", int'(bus1.grant), 0);
        chk("midrst grant_v", int'(bus1.grant_v_o), 0);
        chk("midrst grant_idx", int'(bus1.grant_idx_o), 0);
        chk("midrst occupancy", int'(bus1.occupancy_o), 0);
        chk("midrst err", int'(bus1.err_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("release grant", int'(bus1.grant), 0);
        chk("release occupancy", int'(bus1.occupancy_o), 0);
        apply(mk(2, 4'b0111, 0, 0, 4'b0001, 3, 0), 203);
        apply(mk(2, 4'b0000, 0, 0, 4'b0000, 3, 1), 204);
        apply(mk(2, 4'b0000, 0, 0, 4'b0000, 0, 0), 205);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
